// File: rtl/uart_letter_pkg.sv
// Shared types and constants for the UART letter receiver.
// Holds the receiver FSM state enum, idle line level, ASCII constants and case folding.
package uart_letter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam logic       UART_IDLE_LVL  = 1'b1;
  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  function automatic logic [7:0] fold_case(input logic [7:0] b);
    if (b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
      return b & ~ASCII_CASE_BIT;
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset value.
// Latency 2 cycles; no backpressure.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_letter_rx.sv
// 8N1 UART receiver delivering each byte as an optionally upper-cased letter strobe.
// Latency about 3 + CLK_DIV/2 + 9*CLK_DIV cycles from the start edge; no backpressure.
module uart_letter_rx
  import uart_letter_pkg::*;
#(
  parameter int CLK_DIV = 868,
  parameter bit UPCASE  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       frame_err
);

  localparam int             CW       = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [CW-1:0]  HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]  BIT_END  = CW'(CLK_DIV - 1);

  logic          rx_s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [7:0]    letter_nxt;
  logic          letter_valid_nxt, frame_err_nxt;
  logic          armed, armed_nxt;
  logic [1:0]    settle;

  sync_2ff #(.RST_VAL(UART_IDLE_LVL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // The synchronizer's preset value is not a real sample of the line, so arming
  // waits until the reset value has been flushed out of both flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle <= 2'b00;
    end else begin
      settle <= {settle[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      sh           <= '0;
      letter       <= 8'h00;
      letter_valid <= 1'b0;
      frame_err    <= 1'b0;
      armed        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      sh           <= sh_nxt;
      letter       <= letter_nxt;
      letter_valid <= letter_valid_nxt;
      frame_err    <= frame_err_nxt;
      armed        <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    bit_idx_nxt      = bit_idx;
    sh_nxt           = sh;
    letter_nxt       = letter;
    letter_valid_nxt = 1'b0;
    frame_err_nxt    = 1'b0;
    armed_nxt        = armed | (settle[1] & (rx_s == UART_IDLE_LVL));

    unique case (state)
      IDLE: begin
        if (rx_s != UART_IDLE_LVL && armed) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          if (rx_s == UART_IDLE_LVL) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            state_nxt   = DATA;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          sh_nxt  = {rx_s, sh[7:1]};
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          if (rx_s == UART_IDLE_LVL) begin
            letter_nxt       = UPCASE ? fold_case(sh) : sh;
            letter_valid_nxt = 1'b1;
            state_nxt        = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = BREAK;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s == UART_IDLE_LVL) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
